// File: rtl/ram_block_engine.sv
// ram_block_engine
//   Single-port RAM master that runs block FILL, COPY and CHECK operations
//   over a wrapping address range under a start/busy/done handshake.
//
//   Optional feature macro: RAM_BLOCK_CHECK_EN
//     defined   : CHECK op with mismatch counter and first-mismatch address
//     undefined : op=10 is reserved (err=1, no RAM access); status outputs tied 0
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     start, op             command strobe (IDLE only), 00 FILL 01 COPY 10 CHECK
//     src_addr, dst_addr    COPY source / CHECK base, COPY dest / FILL base
//     len                   word count 0..DEPTH
//     pattern, incr         data seed; word k = pattern + k when incr=1
//     abort                 stop the running op (current access completes)
//     busy, done, err       handshake / status
//     mismatch_cnt          CHECK mismatch count
//     first_mismatch_addr   address of first CHECK mismatch (0 if none)
//     ram_en/we/addr/wdata  RAM port, decoded from registers only
//     ram_rdata             RAM read data, combinational from ram_addr
module ram_block_engine #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic                  incr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   mismatch_cnt,
    output logic [ADDR_WIDTH-1:0] first_mismatch_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, FILL, CP_RD, CP_WR, CHK, FIN} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   k;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [DATA_WIDTH-1:0] pat_q, hold_q, data_k;
    logic                  incr_q;
    logic                  last;
    logic                  op_reserved;

`ifdef RAM_BLOCK_CHECK_EN
    assign op_reserved = (op == 2'b11);
`else
    assign op_reserved = (op[1] == 1'b1);
`endif

    assign last   = (k == len_q - 1'b1);
    assign data_k = incr_q ? pat_q + DATA_WIDTH'(k) : pat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Abort wins over the normal sequencing; the access already on the
    // port this cycle still lands because the RAM samples at the same edge.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) begin
                if (len == '0 || op_reserved) state_n = FIN;
                else if (op == 2'b00)         state_n = FILL;
                else if (op == 2'b01)         state_n = CP_RD;
                else                          state_n = CHK;
            end
            FILL:    if (abort || last) state_n = FIN;
            CP_RD:   state_n = abort ? FIN : CP_WR;
            CP_WR:   state_n = (abort || last) ? FIN : CP_RD;
            CHK:     if (abort || last) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // RAM port and handshake are pure decodes of state and registers.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            FILL: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = dst_q + k[ADDR_WIDTH-1:0];
                ram_wdata = data_k;
            end
            CP_RD, CHK: begin
                ram_en   = 1'b1;
                ram_addr = src_q + k[ADDR_WIDTH-1:0];
            end
            CP_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = dst_q + k[ADDR_WIDTH-1:0];
                ram_wdata = hold_q;
            end
            default: ;
        endcase
    end

    assign busy = (state == FILL) || (state == CP_RD) || (state == CP_WR) || (state == CHK);
    assign done = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            len_q  <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            pat_q  <= '0;
            incr_q <= 1'b0;
            hold_q <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k      <= '0;
                    len_q  <= (len > MAX_LEN) ? MAX_LEN : len;
                    src_q  <= src_addr;
                    dst_q  <= dst_addr;
                    pat_q  <= pattern;
                    incr_q <= incr;
                    err    <= op_reserved;
                end
                FILL, CP_WR, CHK: k <= k + 1'b1;
                CP_RD:            hold_q <= ram_rdata;
                default: ;
            endcase
            if (busy && abort) err <= 1'b1;
        end
    end

`ifdef RAM_BLOCK_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt        <= '0;
            first_mismatch_addr <= '0;
        end else if (state == IDLE && start) begin
            mismatch_cnt        <= '0;
            first_mismatch_addr <= '0;
        end else if (state == CHK && ram_rdata != data_k) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (mismatch_cnt == '0) first_mismatch_addr <= ram_addr;
        end
    end
`else
    assign mismatch_cnt        = '0;
    assign first_mismatch_addr = '0;
`endif

endmodule

// File: tb/tb_ram_block_engine.sv
module tb_ram_block_engine;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, incr = 1'b0, abort = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [AW-1:0] src_addr = '0, dst_addr = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] pattern = '0;
    logic          busy, done, err, ram_en, ram_we;
    logic [AW:0]   mismatch_cnt;
    logic [AW-1:0] first_mismatch_addr, ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    // RAM behind the DUT plus a back-door poke port for preloading
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] refmem [DEPTH];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_data = '0;
    int            wr_count = 0;

    int errors = 0, checks = 0;

    ram_block_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .pattern(pattern), .incr(incr), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .mismatch_cnt(mismatch_cnt), .first_mismatch_addr(first_mismatch_addr),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = AW'(a); tb_data = d;
        refmem[a] = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic cmp_mem(input string name);
        int diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== refmem[i]) diffs++;
        chk(name, 64'(diffs), 64'd0);
    endtask

    task automatic check_all_zero();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_en", 64'(ram_en), 0);
        chk("rst_we", 64'(ram_we), 0);
        chk("rst_addr", 64'(ram_addr), 0);
        chk("rst_wdata", 64'(ram_wdata), 0);
        chk("rst_mmcnt", 64'(mismatch_cnt), 0);
        chk("rst_mmaddr", 64'(first_mismatch_addr), 0);
    endtask

    // Reference: walks the operation word by word against refmem and checks
    // the DUT's port every cycle. abort_at / reset_at are busy-cycle indices
    // (-1 = never). noise toggles start and the command fields while busy.
    task automatic run_op(input logic [1:0] o, input int s, input int d, input int n,
                          input logic [DW-1:0] p, input bit inc,
                          input int abort_at, input int reset_at, input bit noise);
        bit chk_en, reserved, aborted;
        int ncyc, cyc, k, a, mm, first, wc;
        bit exp_we;
        logic [DW-1:0] exp_wd, hold, dk;
`ifdef RAM_BLOCK_CHECK_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        reserved = (o == 2'd3) || (o == 2'd2 && !chk_en);
        ncyc = (reserved || n == 0) ? 0 : (o == 2'd1 ? 2 * n : n);
        mm = 0; first = 0; aborted = 1'b0; cyc = 0; hold = '0;
        @(negedge clk);
        start = 1'b1; op = o; src_addr = AW'(s); dst_addr = AW'(d);
        len = (AW+1)'(n); pattern = p; incr = inc;
        while (cyc < ncyc) begin
            @(negedge clk);
            abort = 1'b0;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                op = 2'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
                len = (AW+1)'($urandom_range(0, 20)); pattern = $urandom; incr = 1'($urandom);
            end
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                #1 check_all_zero();
                wc = wr_count;
                start = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("post_rst_en", 64'(ram_en), 0);
                    chk("post_rst_busy", 64'(busy), 0);
                end
                chk("post_rst_writes", 64'(wr_count), 64'(wc));
                cmp_mem("post_rst_mem");
                return;
            end
            k = (o == 2'd1) ? cyc / 2 : cyc;
            dk = inc ? p + DW'(k) : p;
            exp_wd = '0;
            if (o == 2'd0) begin
                a = (d + k) % DEPTH; exp_we = 1'b1; exp_wd = dk; refmem[a] = dk;
            end else if (o == 2'd1 && cyc % 2 == 0) begin
                a = (s + k) % DEPTH; exp_we = 1'b0; hold = refmem[a];
            end else if (o == 2'd1) begin
                a = (d + k) % DEPTH; exp_we = 1'b1; exp_wd = hold; refmem[a] = hold;
            end else begin
                a = (s + k) % DEPTH; exp_we = 1'b0;
                if (refmem[a] != dk) begin
                    if (mm == 0) first = a;
                    mm++;
                end
            end
            chk("ram_en", 64'(ram_en), 1);
            chk("ram_we", 64'(ram_we), 64'(exp_we));
            chk("ram_addr", 64'(ram_addr), 64'(a));
            if (exp_we) chk("ram_wdata", 64'(ram_wdata), 64'(exp_wd));
            chk("busy", 64'(busy), 1);
            chk("done_low", 64'(done), 0);
            if (cyc == abort_at) begin
                abort = 1'b1; aborted = 1'b1; cyc = ncyc;
            end else cyc++;
        end
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("fin_done", 64'(done), 1);
        chk("fin_busy", 64'(busy), 0);
        chk("fin_en", 64'(ram_en), 0);
        chk("fin_err", 64'(err), 64'(reserved || aborted));
        chk("fin_mmcnt", 64'(mismatch_cnt), 64'(mm));
        chk("fin_mmaddr", 64'(first_mismatch_addr), 64'(first));
        if (noise) begin
            start = 1'b1; op = 2'd0; len = 9'd5;   // must be ignored in FIN
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_done", 64'(done), 0);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_en", 64'(ram_en), 0);
        chk("idle_err_held", 64'(err), 64'(reserved || aborted));
        cmp_mem("mem");
    endtask

    initial begin
        int o, n, ab;
        logic [DW-1:0] v;
        #1 check_all_zero();
        // preload under reset
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero();

        // FILL 0x10..0x13 with A0..A3
        run_op(2'd0, 0, 8'h10, 4, 32'hA0, 1'b1, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            v = mem[8'h10 + i];
            chk("fill_lit", 64'(v), 64'(32'hA0 + i));
        end

        // COPY with wrapping source
        poke(8'hFE, 32'h111); poke(8'hFF, 32'h222); poke(8'h00, 32'h333); poke(8'h01, 32'h444);
        run_op(2'd1, 8'hFE, 8'h40, 4, 0, 1'b0, -1, -1, 1'b0);
        v = mem[8'h40]; chk("copy_lit0", 64'(v), 64'h111);
        v = mem[8'h42]; chk("copy_lit2", 64'(v), 64'h333);
        v = mem[8'h43]; chk("copy_lit3", 64'(v), 64'h444);

        // overlapping forward COPY propagates
        poke(8'h20, 32'h5);
        run_op(2'd1, 8'h20, 8'h21, 3, 0, 1'b0, -1, -1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            v = mem[8'h20 + i];
            chk("overlap_lit", 64'(v), 64'h5);
        end

        // CHECK with one corrupted word
        poke(8'h12, 32'h0);
        run_op(2'd2, 8'h10, 0, 4, 32'hA0, 1'b1, -1, -1, 1'b0);
`ifdef RAM_BLOCK_CHECK_EN
        chk("check_cnt_lit", 64'(mismatch_cnt), 64'd1);
        chk("check_addr_lit", 64'(first_mismatch_addr), 64'h12);
        chk("check_err_lit", 64'(err), 64'd0);
`else
        chk("check_disabled_err_lit", 64'(err), 64'd1);
`endif

        // len=0 and reserved op: no RAM access
        run_op(2'd0, 0, 8'h80, 0, 32'h1, 1'b0, -1, -1, 1'b0);
        chk("len0_err_lit", 64'(err), 64'd0);
        run_op(2'd3, 8'h10, 8'h80, 5, 32'h1, 1'b0, -1, -1, 1'b0);
        chk("op3_err_lit", 64'(err), 64'd1);

        // abort FILL at k=5: words 0..5 written
        poke(8'h66, 32'hDEAD);
        run_op(2'd0, 0, 8'h60, 16, 32'h100, 1'b1, 5, -1, 1'b0);
        v = mem[8'h65]; chk("abort_last_lit", 64'(v), 64'h105);
        v = mem[8'h66]; chk("abort_next_lit", 64'(v), 64'hDEAD);

        // abort COPY in a read cycle (no write) and in a write cycle
        run_op(2'd1, 8'h30, 8'h90, 6, 0, 1'b0, 4, -1, 1'b0);
        run_op(2'd1, 8'h30, 8'h90, 6, 0, 1'b0, 3, -1, 1'b0);

        // full range FILL wrapping from 0xF0
        run_op(2'd0, 0, 8'hF0, DEPTH, 32'h7000, 1'b1, -1, -1, 1'b0);
        v = mem[8'hEF]; chk("full_lit", 64'(v), 64'h70FF);

        // randomized ops with command noise and occasional abort
        for (int t = 0; t < 40; t++) begin
            o = $urandom_range(0, 3);
            n = ($urandom_range(0, 9) == 0) ? DEPTH : $urandom_range(0, 12);
            ab = -1;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 2 * n + 1);
            run_op(2'(o), $urandom_range(0, 255), $urandom_range(0, 255), n,
                   $urandom, 1'($urandom), ab, -1, 1'b1);
        end

        // reset mid-COPY during a write cycle
        run_op(2'd1, 8'h30, 8'hC0, 10, 0, 1'b0, -1, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
